// File: rtl/mem_access_ctl.sv
// Memory access stage: latches the effective address into MAR, runs a fixed
// wait-state SRAM bus cycle (optionally via a pointer fetch) and returns data in MDR.
module mem_access_ctl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Write,
    input  logic        Indirect,
    input  logic [15:0] ADDR_IN,
    input  logic [15:0] DATA_IN,
    input  logic [15:0] Mem_Data_In,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Mem_ADDR,
    output logic [15:0] Mem_Data_Out,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic [15:0] wdata_q;
    logic        write_q;
    logic [3:0]  count_q;
    logic        last_cycle;

    assign last_cycle = (count_q == LAST_COUNT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes and status decode purely from the registered state, so no
    // request input can reach the memory bus combinationally.
    always_comb begin
        state_next   = state;
        Busy         = 1'b1;
        Done         = 1'b0;
        Mem_CE       = 1'b1;
        Mem_OE       = 1'b1;
        Mem_WE       = 1'b1;
        Mem_Data_Out = 16'h0000;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    if (Indirect) begin
                        state_next = PTR;
                    end else if (Write) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            PTR: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                if (last_cycle) begin
                    state_next = write_q ? WR : RD;
                end
            end
            RD: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            WR: begin
                Mem_CE       = 1'b0;
                Mem_WE       = 1'b0;
                Mem_Data_Out = wdata_q;
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The pointer fetch overwrites MAR in place, so the final access follows
    // on the very next cycle without an idle gap on the bus.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            wdata_q <= 16'h0000;
            write_q <= 1'b0;
            count_q <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mar_q   <= ADDR_IN;
                        wdata_q <= DATA_IN;
                        write_q <= Write;
                        count_q <= 4'd0;
                    end
                end
                PTR: begin
                    if (last_cycle) begin
                        mar_q   <= Mem_Data_In;
                        count_q <= 4'd0;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
                RD: begin
                    if (last_cycle) begin
                        mdr_q   <= Mem_Data_In;
                        count_q <= 4'd0;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
                WR: begin
                    if (last_cycle) begin
                        mdr_q   <= wdata_q;
                        count_q <= 4'd0;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
                default: begin
                    count_q <= 4'd0;
                end
            endcase
        end
    end

    assign MAR      = mar_q;
    assign MDR      = mdr_q;
    assign Mem_ADDR = mar_q;

endmodule

// File: tb/tb_mem_access_ctl.sv
// Scoreboard bench for mem_access_ctl: one instance with two wait states,
// one with a single wait state, both served by the same memory model.
module tb_mem_access_ctl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        write;
    logic        indirect;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] mem_rd;
    logic [15:0] mem_rd1;

    logic        busy, done, ce, oe, we;
    logic [15:0] mar, mdr, mem_addr, mem_dout;
    logic        busy1, done1, ce1, oe1, we1;
    logic [15:0] mar1, mdr1, mem_addr1, mem_dout1;

    logic [15:0] mem [0:65535];
    logic [15:0] sb [$];
    logic [15:0] sb1 [$];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int oe_clash = 0;
    logic [15:0] wr_addr_log = 16'h0000;
    logic [15:0] wr_data_log = 16'h0000;

    mem_access_ctl #(.WAIT_CYCLES(2)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Write(write), .Indirect(indirect),
        .ADDR_IN(addr_in), .DATA_IN(data_in), .Mem_Data_In(mem_rd),
        .Busy(busy), .Done(done), .MAR(mar), .MDR(mdr), .Mem_ADDR(mem_addr),
        .Mem_Data_Out(mem_dout), .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(we)
    );

    mem_access_ctl #(.WAIT_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(reset), .Start(start), .Write(write), .Indirect(indirect),
        .ADDR_IN(addr_in), .DATA_IN(data_in), .Mem_Data_In(mem_rd1),
        .Busy(busy1), .Done(done1), .MAR(mar1), .MDR(mdr1), .Mem_ADDR(mem_addr1),
        .Mem_Data_Out(mem_dout1), .Mem_CE(ce1), .Mem_OE(oe1), .Mem_WE(we1)
    );

    assign mem_rd  = mem[mem_addr];
    assign mem_rd1 = mem[mem_addr1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus-side write monitor for the two-wait-state instance.
    always @(posedge clk) begin
        if (!ce && !we) begin
            wr_addr_log <= mem_addr;
            wr_data_log <= mem_dout;
            wr_cnt      <= wr_cnt + 1;
            if (!oe) begin
                oe_clash <= oe_clash + 1;
            end
        end
    end

    task automatic issue(input logic wr, input logic ind, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        start    = 1'b1;
        write    = wr;
        indirect = ind;
        addr_in  = a;
        data_in  = d;
        @(negedge clk);
        start    = 1'b0;
        write    = 1'b0;
        indirect = 1'b0;
        addr_in  = 16'($urandom);
        data_in  = 16'($urandom);
    endtask

    task automatic run_until_done(input int from, output int lat, output int ce_n, output int we_n);
        lat  = from;
        ce_n = 0;
        we_n = 0;
        while (!done && lat < 40) begin
            if (!ce) ce_n++;
            if (!we) we_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b0;
        write    = 1'b0;
        indirect = 1'b0;
        addr_in  = 16'h0000;
        data_in  = 16'h0000;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
        total++; if ({ce, oe, we} !== 3'b111) begin bad++; $display("[TB] FAIL reset_strobes got=%b exp=111", {ce, oe, we}); end
        total++; if (mar !== 16'h0000) begin bad++; $display("[TB] FAIL reset_mar got=%h exp=0000", mar); end
        total++; if (mdr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_mdr got=%h exp=0000", mdr); end
        total++; if (mem_dout !== 16'h0000) begin bad++; $display("[TB] FAIL reset_dout got=%h exp=0000", mem_dout); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy1 got=%0b exp=0", busy1); end
        reset = 1'b0;
    endtask

    task automatic test_direct_load;
        int lat, cen, wen;
        logic [15:0] exp;
        mem[16'h3000] = 16'hBEEF;
        sb.push_back(16'hBEEF);
        issue(1'b0, 1'b0, 16'h3000, 16'h5555);
        total++; if (mem_addr !== 16'h3000) begin bad++; $display("[TB] FAIL ld_addr got=%h exp=3000", mem_addr); end
        total++; if ({ce, oe, we} !== 3'b001) begin bad++; $display("[TB] FAIL ld_strobes got=%b exp=001", {ce, oe, we}); end
        run_until_done(1, lat, cen, wen);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL ld_latency got=%0d exp=3", lat); end
        total++; if (cen !== 2) begin bad++; $display("[TB] FAIL ld_ce_cycles got=%0d exp=2", cen); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL ld_mdr got=%h exp=%h", mdr, exp); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ld_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_direct_store;
        int lat, cen, wen, w0, clash0;
        logic [15:0] exp;
        w0     = wr_cnt;
        clash0 = oe_clash;
        sb.push_back(16'h1234);
        issue(1'b1, 1'b0, 16'h4010, 16'h1234);
        total++; if (mem_dout !== 16'h1234) begin bad++; $display("[TB] FAIL st_dout got=%h exp=1234", mem_dout); end
        total++; if ({ce, oe, we} !== 3'b010) begin bad++; $display("[TB] FAIL st_strobes got=%b exp=010", {ce, oe, we}); end
        run_until_done(1, lat, cen, wen);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL st_latency got=%0d exp=3", lat); end
        total++; if (wen !== 2) begin bad++; $display("[TB] FAIL st_we_cycles got=%0d exp=2", wen); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("[TB] FAIL st_bus_writes got=%0d exp=2", wr_cnt - w0); end
        total++; if (wr_addr_log !== 16'h4010) begin bad++; $display("[TB] FAIL st_bus_addr got=%h exp=4010", wr_addr_log); end
        total++; if (oe_clash !== clash0) begin bad++; $display("[TB] FAIL st_oe_clash got=%0d exp=%0d", oe_clash, clash0); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL st_mdr got=%h exp=%h", mdr, exp); end
        @(negedge clk);
        total++; if (mem_dout !== 16'h0000) begin bad++; $display("[TB] FAIL st_dout_after got=%h exp=0000", mem_dout); end
    endtask

    task automatic test_indirect_load;
        int lat, cen, wen;
        logic [15:0] exp;
        mem[16'h3005] = 16'h5000;
        mem[16'h5000] = 16'h00AA;
        sb.push_back(16'h00AA);
        issue(1'b0, 1'b1, 16'h3005, 16'h0000);
        total++; if (mar !== 16'h3005) begin bad++; $display("[TB] FAIL ildi_mar_c1 got=%h exp=3005", mar); end
        @(negedge clk);
        total++; if (mar !== 16'h3005) begin bad++; $display("[TB] FAIL ildi_mar_c2 got=%h exp=3005", mar); end
        @(negedge clk);
        total++; if (mar !== 16'h5000) begin bad++; $display("[TB] FAIL ildi_mar_c3 got=%h exp=5000", mar); end
        total++; if ({ce, oe} !== 2'b00) begin bad++; $display("[TB] FAIL ildi_no_gap got=%b exp=00", {ce, oe}); end
        run_until_done(3, lat, cen, wen);
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL ildi_latency got=%0d exp=5", lat); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL ildi_mdr got=%h exp=%h", mdr, exp); end
    endtask

    task automatic test_indirect_store;
        int lat, cen, wen, w0;
        logic [15:0] exp;
        mem[16'hFFFF] = 16'h0000;
        mem[16'h0000] = 16'h1111;
        w0 = wr_cnt;
        sb.push_back(16'hCAFE);
        issue(1'b1, 1'b1, 16'hFFFF, 16'hCAFE);
        total++; if (mar !== 16'hFFFF) begin bad++; $display("[TB] FAIL isti_mar_c1 got=%h exp=ffff", mar); end
        total++; if (oe !== 1'b0) begin bad++; $display("[TB] FAIL isti_ptr_oe got=%0b exp=0", oe); end
        run_until_done(1, lat, cen, wen);
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL isti_latency got=%0d exp=5", lat); end
        total++; if (cen !== 4) begin bad++; $display("[TB] FAIL isti_ce_cycles got=%0d exp=4", cen); end
        total++; if (wen !== 2) begin bad++; $display("[TB] FAIL isti_we_cycles got=%0d exp=2", wen); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("[TB] FAIL isti_bus_writes got=%0d exp=2", wr_cnt - w0); end
        total++; if (wr_addr_log !== 16'h0000) begin bad++; $display("[TB] FAIL isti_bus_addr got=%h exp=0000", wr_addr_log); end
        total++; if (wr_data_log !== 16'hCAFE) begin bad++; $display("[TB] FAIL isti_bus_data got=%h exp=cafe", wr_data_log); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL isti_mdr got=%h exp=%h", mdr, exp); end
    endtask

    task automatic test_back_to_back;
        int lat, cen, wen;
        logic [15:0] exp;
        mem[16'h2000] = 16'h1357;
        mem[16'h2200] = 16'h2468;
        @(negedge clk);
        start    = 1'b1;
        write    = 1'b0;
        indirect = 1'b0;
        addr_in  = 16'h2000;
        sb.push_back(16'h1357);
        @(negedge clk);
        total++; if (mar !== 16'h2000) begin bad++; $display("[TB] FAIL b2b_mar_c1 got=%h exp=2000", mar); end
        addr_in = 16'h2101;
        @(negedge clk);
        total++; if (mar !== 16'h2000) begin bad++; $display("[TB] FAIL b2b_mar_c2 got=%h exp=2000", mar); end
        addr_in = 16'h2102;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done_c3 got=%0b exp=1", done); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL b2b_mdr1 got=%h exp=%h", mdr, exp); end
        addr_in = 16'h2103;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_c4 got=%0b exp=0", busy); end
        total++; if (mar !== 16'h2000) begin bad++; $display("[TB] FAIL b2b_mar_c4 got=%h exp=2000", mar); end
        addr_in = 16'h2200;
        sb.push_back(16'h2468);
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy_c5 got=%0b exp=1", busy); end
        total++; if (mar !== 16'h2200) begin bad++; $display("[TB] FAIL b2b_mar_c5 got=%h exp=2200", mar); end
        run_until_done(1, lat, cen, wen);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL b2b_latency2 got=%0d exp=3", lat); end
        exp = sb.pop_front();
        total++; if (mdr !== exp) begin bad++; $display("[TB] FAIL b2b_mdr2 got=%h exp=%h", mdr, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int done_seen;
        mem[16'h6000] = 16'h9999;
        issue(1'b0, 1'b0, 16'h6000, 16'h0000);
        @(negedge clk);
        total++; if (ce !== 1'b0) begin bad++; $display("[TB] FAIL abort_in_rd got=%0b exp=0", ce); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%0b exp=0", busy); end
        total++; if ({ce, oe, we} !== 3'b111) begin bad++; $display("[TB] FAIL abort_strobes got=%b exp=111", {ce, oe, we}); end
        total++; if (mar !== 16'h0000) begin bad++; $display("[TB] FAIL abort_mar got=%h exp=0000", mar); end
        total++; if (mdr !== 16'h0000) begin bad++; $display("[TB] FAIL abort_mdr got=%h exp=0000", mdr); end
        done_seen = 0;
        repeat (4) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        total++; if (done_seen !== 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_seen); end
    endtask

    task automatic test_wait1;
        int lat;
        logic [15:0] exp;
        mem[16'h7000] = 16'h0F0F;
        sb1.push_back(16'h0F0F);
        issue(1'b0, 1'b0, 16'h7000, 16'h0000);
        total++; if ({ce1, oe1} !== 2'b00) begin bad++; $display("[TB] FAIL w1_strobes got=%b exp=00", {ce1, oe1}); end
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL w1_latency got=%0d exp=2", lat); end
        exp = sb1.pop_front();
        total++; if (mdr1 !== exp) begin bad++; $display("[TB] FAIL w1_mdr got=%h exp=%h", mdr1, exp); end
        repeat (2) @(negedge clk);
        issue(1'b0, 1'b0, 16'h7100, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL w1_abort_busy got=%0b exp=0", busy1); end
        total++; if ({ce1, oe1, we1} !== 3'b111) begin bad++; $display("[TB] FAIL w1_abort_strobes got=%b exp=111", {ce1, oe1, we1}); end
        total++; if (mar1 !== 16'h0000) begin bad++; $display("[TB] FAIL w1_abort_mar got=%h exp=0000", mar1); end
        total++; if (mdr1 !== 16'h0000) begin bad++; $display("[TB] FAIL w1_abort_mdr got=%h exp=0000", mdr1); end
    endtask

    initial begin
        test_reset();
        test_direct_load();
        test_direct_store();
        test_indirect_load();
        test_indirect_store();
        test_back_to_back();
        test_reset_abort();
        test_wait1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
